// File: rtl/wavetable_pkg.sv
// Shared wavetable definitions: slot geometry, loader state encoding and the
// playback scale table.
package wavetable_pkg;

    localparam int POS_W            = 13;
    localparam int SEL_W            = 2;
    localparam int DATA_W           = 16;
    localparam int ADDR_W           = SEL_W + POS_W;
    localparam int SAMPLES_PER_WAVE = 8192;

    // Amplitude scale steps applied by the playback side (255 = unity).
    localparam logic [7:0] SCALE_TABLE [0:7] = '{
        8'd255, 8'd180, 8'd128, 8'd90, 8'd64, 8'd45, 8'd32, 8'd23
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LO,
        ST_GET_HI,
        ST_WRITE,
        ST_WAIT_DONE,
        ST_FINISH
    } loader_state_t;

endpackage

// File: rtl/loader_done_timer.sv
// Watchdog for the dpram_ctrl handshake: counts cycles spent waiting for
// mem_done and flags expiry on the last permitted waiting cycle.
module loader_done_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_50,
    input  logic daclrck,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples its pre-edge value.
    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // With the count cleared on the write cycle, expiry lands on waiting cycle TIMEOUT.
    assign expired = run && !clear && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wave_table_loader.sv
// Fills one wave slot of the dpram from a byte stream: byte pairs become
// {first, second} words written through the dpram_ctrl write port.
module wave_table_loader
    import wavetable_pkg::*;
#(
    parameter int DONE_TIMEOUT = 255
) (
    input  logic              clk_50,
    input  logic              daclrck,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  wave_sel,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr,
    input  logic              mem_done,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [POS_W:0]    sample_count
);

    loader_state_t     state_q, state_d;
    logic [SEL_W-1:0]  slot_q, slot_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [POS_W:0]    count_q, count_d;
    logic              err_q, err_d;

    logic timer_clear;
    logic timer_run;
    logic timer_expired;
    logic last_pos;

    assign timer_clear = (state_q == ST_WRITE);
    assign timer_run   = (state_q == ST_WAIT_DONE);
    assign last_pos    = (pos_q == POS_W'(SAMPLES_PER_WAVE - 1));

    loader_done_timer #(
        .TIMEOUT (DONE_TIMEOUT)
    ) u_done_timer (
        .clk_50  (clk_50),
        .daclrck (daclrck),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        pos_d   = pos_q;
        din_d   = din_q;
        count_d = count_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    slot_d  = wave_sel;
                    pos_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_GET_LO;
                end
            end
            ST_GET_LO: begin
                if (byte_valid) begin
                    din_d[DATA_W-1 -: 8] = byte_in;
                    state_d              = ST_GET_HI;
                end
            end
            ST_GET_HI: begin
                if (byte_valid) begin
                    din_d[7:0] = byte_in;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mem_done) begin
                    count_d = count_q + 1'b1;
                    if (last_pos) begin
                        state_d = ST_FINISH;
                    end else begin
                        pos_d   = pos_q + 1'b1;
                        state_d = ST_GET_LO;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort outranks a coincident mem_done: the word is not counted.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            pos_d   = pos_q;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            pos_q   <= '0;
            din_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pos_q   <= pos_d;
            din_q   <= din_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign byte_ready   = (state_q == ST_GET_LO) || (state_q == ST_GET_HI);
    assign mem_wr       = (state_q == ST_WRITE);
    assign busy         = (state_q != ST_IDLE);
    assign load_done    = (state_q == ST_FINISH);
    assign load_err     = err_q;
    assign mem_addr     = {slot_q, pos_q};
    assign mem_din      = din_q;
    assign sample_count = count_q;

endmodule
